sch_test_slave: RTL and testbench
=================================

# sch_test_slave

Self-contained 16-bit SPI loopback test block: an SPI master and an SPI slave on one chip, wired MOSI/MISO/SCLK/LOAD to each other. A one-cycle start pulse exchanges `MTX_DAT` (master) and `STX_DAT` (slave) in one full-duplex frame. All internal shift registers, the bit counter and the bit-rate enable are exported for lab observation and verification.

## Interface
- `TACT_DIV`, default 4: clk cycles per SCLK half-period; legal range ≥ 2.
- `clk` in 1: system clock; all logic on its rising edge.
- `RESET` in 1: asynchronous, active-low reset.
- `st` in 1: start strobe, sampled only while idle.
- `MTX_DAT` in 16: master transmit word.
- `STX_DAT` in 16: slave transmit word.
- `LOAD` out 1: frame select. 1 = idle, 0 = frame in progress.
- `SCLK` out 1: serial clock, idle 0 (SPI mode 0).
- `MOSI` out 1: master data out.
- `MISO` out 1: slave data out.
- `MRX_DAT` out 16: word received by the master, updated at frame end.
- `SRX_DAT` out 16: word received by the slave, updated at frame end.
- `sr_MTX`, `sr_MRX`, `sr_STX`, `sr_SRX` out 16 each: master TX/RX and slave TX/RX shift registers.
- `cb_bit` out 8: count of completed bits in the current or last frame.
- `ce_tact` out 1: one-cycle half-bit enable.

## Operation
- **Reset values:** `LOAD`=1, `SCLK`=0, `ce_tact`=0, `cb_bit`=0, all shift and data registers 0, so `MOSI`=`MISO`=0.
- **Idle to busy:** when `st`=1 and `LOAD`=1 at a clk edge, on that edge:
  - `LOAD`←0, `sr_MTX`←`MTX_DAT`, `sr_STX`←`STX_DAT`.
  - `sr_MRX`, `sr_SRX`, `cb_bit` and the prescaler are cleared.
- **`st` while busy** is ignored.
- **Data outputs:** `MOSI`=`sr_MTX[15]`, `MISO`=`sr_STX[15]` (MSB first).
- **Prescaler:** runs only while `LOAD`=0. `ce_tact`=1 for one cycle every `TACT_DIV` cycles; `ce_tact` is 0 when idle.
- **On each `ce_tact`, `SCLK` toggles:**
  - Rising edge (`SCLK` was 0): `sr_MRX`←{`sr_MRX[14:0]`,`MISO`}, `sr_SRX`←{`sr_SRX[14:0]`,`MOSI`}.
  - Falling edge (`SCLK` was 1): `sr_MTX`, `sr_STX` shift left with 0 fill; `cb_bit`←`cb_bit`+1.
- **Frame end:** on the falling edge that makes `cb_bit`=16, on the same edge `LOAD`←1, `MRX_DAT`←`sr_MRX`, `SRX_DAT`←`sr_SRX`.
- **Hold:** `cb_bit` holds 16 and shift registers hold until the next start.
- **Input changes:** `MTX_DAT`/`STX_DAT` changes during a frame have no effect.
- **Reset mid-frame:** aborts immediately to reset values. `MRX_DAT`/`SRX_DAT` are cleared, not updated.

## Timing
- Edge N samples `st`=1; `LOAD` falls after edge N.
- First `ce_tact` (first SCLK rise) at edge N+`TACT_DIV`.
- SCLK period is 2·`TACT_DIV` cycles; 16 periods per frame.
- `LOAD` low for exactly 32·`TACT_DIV` cycles; `MRX_DAT`/`SRX_DAT` valid from the same edge `LOAD` rises.
- Earliest next start is the cycle after `LOAD` returns to 1.
- Defaults: 128 cycles per frame.

## Configuration
- `SCH_TEST_SLAVE_LSB_FIRST_EN` defined: LSB-first frame.
  - `MOSI`=`sr_MTX[0]`, `MISO`=`sr_STX[0]`.
  - TX registers shift right with 0 fill.
  - RX registers shift in at bit 15: {bit, `sr[15:1]`}.
- Not defined: MSB-first as above. Timing is identical in both modes.

## Structure
- **Package `sch_test_pkg`:** `WORD_W`=16, `CB_W`=8, `FRAME_BITS`=16, default `TACT_DIV`.
- **Sub-module `spi_slave16`:** holds `sr_STX`/`sr_SRX`, driven by `LOAD`, `SCLK` edge strobes and `MOSI`; produces `MISO` and `SRX_DAT`.
- **Top level:** master, prescaler and bit counter.

## Test plan
1. **Reset:** hold `RESET`=0 → `LOAD`=1, `SCLK`=0, `cb_bit`=0, all 16-bit outputs 0000.
2. **Single frame:** `MTX_DAT`=1234, `STX_DAT`=5678, one-cycle `st` → `LOAD` low 128 cycles; then `MRX_DAT`=5678, `SRX_DAT`=1234, `cb_bit`=16, `LOAD`=1.
3. **Bit order and timing:** during frame 2, `MOSI` at successive SCLK rises = 0,0,0,1,0,0,1,0…; the first rise is 4 cycles after `LOAD` falls.
4. **`st` while busy, inputs changed:** `st` held high through a frame, with `MTX_DAT` changed mid-frame → exactly one frame, result from the value latched at start. Next frame with ABCD/FFFF → `MRX_DAT`=FFFF, `SRX_DAT`=ABCD.
5. **Abort:** assert `RESET` after 5 bits → all reset values at once; no `MRX_DAT` update; a following frame completes normally.
6. **LSB-first build:** with the macro defined, 1234/5678 frame → same results; first `MOSI` bit = 0 (`MTX_DAT[0]`).

Source files
------------

// File: rtl/sch_test_pkg.sv
// Shared constants, FSM state type and bit-order helpers for the SPI loopback block.
// Build macro SCH_TEST_SLAVE_LSB_FIRST_EN selects an LSB-first frame.
package sch_test_pkg;

    localparam int WORD_W       = 16;
    localparam int CB_W         = 8;
    localparam int FRAME_BITS   = 16;
    localparam int TACT_DIV_DEF = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_e;

    // The three helpers below are the only place where bit order is decided.
    function automatic logic txBit(input logic [WORD_W-1:0] sr);
`ifdef SCH_TEST_SLAVE_LSB_FIRST_EN
        return sr[0];
`else
        return sr[WORD_W-1];
`endif
    endfunction

    function automatic logic [WORD_W-1:0] txShift(input logic [WORD_W-1:0] sr);
`ifdef SCH_TEST_SLAVE_LSB_FIRST_EN
        return {1'b0, sr[WORD_W-1:1]};
`else
        return {sr[WORD_W-2:0], 1'b0};
`endif
    endfunction

    function automatic logic [WORD_W-1:0] rxShift(input logic [WORD_W-1:0] sr, input logic b);
`ifdef SCH_TEST_SLAVE_LSB_FIRST_EN
        return {b, sr[WORD_W-1:1]};
`else
        return {sr[WORD_W-2:0], b};
`endif
    endfunction

endpackage

// File: rtl/spi_slave16.sv
// SPI slave half of the loopback: TX/RX shift registers and the received word.
// Bit order follows SCH_TEST_SLAVE_LSB_FIRST_EN through the package helpers.
module spi_slave16
    import sch_test_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    input  logic              rise_i,
    input  logic              fall_i,
    input  logic              done_i,
    input  logic              mosi_i,
    input  logic [WORD_W-1:0] stxDat_i,
    output logic              miso_o,
    output logic [WORD_W-1:0] srStx_o,
    output logic [WORD_W-1:0] srSrx_o,
    output logic [WORD_W-1:0] srxDat_o
);

    logic [WORD_W-1:0] srStx_q, srStx_d;
    logic [WORD_W-1:0] srSrx_q, srSrx_d;
    logic [WORD_W-1:0] srxDat_q, srxDat_d;

    always_comb begin
        srStx_d  = srStx_q;
        srSrx_d  = srSrx_q;
        srxDat_d = srxDat_q;
        if (start_i) begin
            srStx_d = stxDat_i;
            srSrx_d = '0;
        end else begin
            if (rise_i) srSrx_d = rxShift(srSrx_q, mosi_i);
            if (fall_i) srStx_d = txShift(srStx_q);
            // The receive register is already complete before the last falling edge.
            if (done_i) srxDat_d = srSrx_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            srStx_q  <= '0;
            srSrx_q  <= '0;
            srxDat_q <= '0;
        end else begin
            srStx_q  <= srStx_d;
            srSrx_q  <= srSrx_d;
            srxDat_q <= srxDat_d;
        end
    end

    assign miso_o   = txBit(srStx_q);
    assign srStx_o  = srStx_q;
    assign srSrx_o  = srSrx_q;
    assign srxDat_o = srxDat_q;

endmodule

// File: rtl/sch_test_slave.sv
// 16-bit SPI loopback test block: master, prescaler and bit counter around spi_slave16.
// Define SCH_TEST_SLAVE_LSB_FIRST_EN for an LSB-first frame; timing is unchanged.
module sch_test_slave
    import sch_test_pkg::*;
#(
    parameter int TACT_DIV = TACT_DIV_DEF
) (
    input  logic              clk,
    input  logic              RESET,
    input  logic              st,
    input  logic [WORD_W-1:0] MTX_DAT,
    input  logic [WORD_W-1:0] STX_DAT,
    output logic              LOAD,
    output logic              SCLK,
    output logic              MOSI,
    output logic              MISO,
    output logic [WORD_W-1:0] MRX_DAT,
    output logic [WORD_W-1:0] SRX_DAT,
    output logic [WORD_W-1:0] sr_MTX,
    output logic [WORD_W-1:0] sr_MRX,
    output logic [WORD_W-1:0] sr_STX,
    output logic [WORD_W-1:0] sr_SRX,
    output logic [CB_W-1:0]   cb_bit,
    output logic              ce_tact
);

    localparam int PS_W = (TACT_DIV > 2) ? $clog2(TACT_DIV) : 1;

    state_e            state_q, state_d;
    logic [PS_W-1:0]   psCnt_q, psCnt_d;
    logic              sclk_q, sclk_d;
    logic [WORD_W-1:0] srMtx_q, srMtx_d;
    logic [WORD_W-1:0] srMrx_q, srMrx_d;
    logic [WORD_W-1:0] mrxDat_q, mrxDat_d;
    logic [CB_W-1:0]   cbBit_q, cbBit_d;

    logic busy, startPulse, ceTact, riseStb, fallStb, frameDone;
    logic mosiW, misoW;

    assign busy       = (state_q == ST_BUSY);
    assign startPulse = st && !busy;
    assign ceTact     = busy && (psCnt_q == PS_W'(TACT_DIV - 1));
    assign riseStb    = ceTact && !sclk_q;
    assign fallStb    = ceTact && sclk_q;
    assign frameDone  = fallStb && (cbBit_q == CB_W'(FRAME_BITS - 1));

    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (st)        state_d = ST_BUSY;
            ST_BUSY: if (frameDone) state_d = ST_IDLE;
            default:                state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        LOAD    = (state_q == ST_IDLE);
        ce_tact = ceTact;
    end

    always_comb begin
        psCnt_d  = psCnt_q;
        sclk_d   = sclk_q;
        srMtx_d  = srMtx_q;
        srMrx_d  = srMrx_q;
        mrxDat_d = mrxDat_q;
        cbBit_d  = cbBit_q;
        if (startPulse) begin
            psCnt_d = '0;
            sclk_d  = 1'b0;
            srMtx_d = MTX_DAT;
            srMrx_d = '0;
            cbBit_d = '0;
        end else if (busy) begin
            psCnt_d = ceTact ? '0 : psCnt_q + PS_W'(1);
            if (ceTact)    sclk_d   = ~sclk_q;
            if (riseStb)   srMrx_d  = rxShift(srMrx_q, misoW);
            if (fallStb) begin
                srMtx_d = txShift(srMtx_q);
                cbBit_d = cbBit_q + CB_W'(1);
            end
            if (frameDone) mrxDat_d = srMrx_q;
        end
    end

    always_ff @(posedge clk or negedge RESET) begin
        if (!RESET) begin
            psCnt_q  <= '0;
            sclk_q   <= 1'b0;
            srMtx_q  <= '0;
            srMrx_q  <= '0;
            mrxDat_q <= '0;
            cbBit_q  <= '0;
        end else begin
            psCnt_q  <= psCnt_d;
            sclk_q   <= sclk_d;
            srMtx_q  <= srMtx_d;
            srMrx_q  <= srMrx_d;
            mrxDat_q <= mrxDat_d;
            cbBit_q  <= cbBit_d;
        end
    end

    assign mosiW = txBit(srMtx_q);

    spi_slave16 uSlave (
        .clk      (clk),
        .rst_n    (RESET),
        .start_i  (startPulse),
        .rise_i   (riseStb),
        .fall_i   (fallStb),
        .done_i   (frameDone),
        .mosi_i   (mosiW),
        .stxDat_i (STX_DAT),
        .miso_o   (misoW),
        .srStx_o  (sr_STX),
        .srSrx_o  (sr_SRX),
        .srxDat_o (SRX_DAT)
    );

    assign SCLK    = sclk_q;
    assign MOSI    = mosiW;
    assign MISO    = misoW;
    assign MRX_DAT = mrxDat_q;
    assign sr_MTX  = srMtx_q;
    assign sr_MRX  = srMrx_q;
    assign cb_bit  = cbBit_q;

endmodule

// File: tb/tb_sch_test_slave.sv
// Self-checking bench for sch_test_slave: directed and random loopback frames against a frame-level model.
// Honours SCH_TEST_SLAVE_LSB_FIRST_EN for the expected serial bit order.
module tb_sch_test_slave;

    localparam int TACT_DIV = 4;

    logic        clk = 1'b0;
    logic        RESET;
    logic        st;
    logic [15:0] MTX_DAT, STX_DAT;
    logic        LOAD, SCLK, MOSI, MISO, ce_tact;
    logic [15:0] MRX_DAT, SRX_DAT, sr_MTX, sr_MRX, sr_STX, sr_SRX;
    logic [7:0]  cb_bit;

    int checkCnt = 0;
    int passCnt  = 0;
    int failCnt  = 0;

    sch_test_slave #(.TACT_DIV(TACT_DIV)) dut (
        .clk     (clk),
        .RESET   (RESET),
        .st      (st),
        .MTX_DAT (MTX_DAT),
        .STX_DAT (STX_DAT),
        .LOAD    (LOAD),
        .SCLK    (SCLK),
        .MOSI    (MOSI),
        .MISO    (MISO),
        .MRX_DAT (MRX_DAT),
        .SRX_DAT (SRX_DAT),
        .sr_MTX  (sr_MTX),
        .sr_MRX  (sr_MRX),
        .sr_STX  (sr_STX),
        .sr_SRX  (sr_SRX),
        .cb_bit  (cb_bit),
        .ce_tact (ce_tact)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checkCnt++;
        assert (obs === exp) passCnt++;
        else begin
            failCnt++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Order in which a word leaves the wire, written MSB-first as a 16-bit pattern.
    function automatic logic [15:0] wireOrder(input logic [15:0] w);
        logic [15:0] r;
        r = '0;
        for (int k = 0; k < 16; k++) begin
`ifdef SCH_TEST_SLAVE_LSB_FIRST_EN
            r[15-k] = w[k];
`else
            r[15-k] = w[15-k];
`endif
        end
        return r;
    endfunction

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_LOAD"},   LOAD,    1);
        checkOutput({tag, "_SCLK"},   SCLK,    0);
        checkOutput({tag, "_cb"},     cb_bit,  0);
        checkOutput({tag, "_ce"},     ce_tact, 0);
        checkOutput({tag, "_MOSI"},   MOSI,    0);
        checkOutput({tag, "_MISO"},   MISO,    0);
        checkOutput({tag, "_MRX"},    MRX_DAT, 0);
        checkOutput({tag, "_SRX"},    SRX_DAT, 0);
        checkOutput({tag, "_srMTX"},  sr_MTX,  0);
        checkOutput({tag, "_srMRX"},  sr_MRX,  0);
        checkOutput({tag, "_srSTX"},  sr_STX,  0);
        checkOutput({tag, "_srSRX"},  sr_SRX,  0);
    endtask

    // One full frame: start, observe the wire at every SCLK rise, then check the result.
    task automatic applyStimulus(input logic [15:0] m, input logic [15:0] s,
                                 input bit holdSt, input bit changeMid, input string tag);
        logic [15:0] seqM, seqS;
        int  lowCnt, rises, firstRise;
        bit  prev, done;
        @(negedge clk);
        MTX_DAT = m;
        STX_DAT = s;
        st      = 1'b1;
        @(posedge clk);
        prev = 1'b0; done = 1'b0; lowCnt = 0; rises = 0; firstRise = -1;
        seqM = '0; seqS = '0;
        for (int c = 1; c <= 40 * TACT_DIV && !done; c++) begin
            @(negedge clk);
            if (!holdSt) st = 1'b0;
            if (LOAD) begin
                done = 1'b1;
            end else begin
                lowCnt++;
                if (SCLK && !prev) begin
                    if (firstRise < 0) firstRise = c;
                    if (rises < 16) begin
                        seqM[15-rises] = MOSI;
                        seqS[15-rises] = MISO;
                    end
                    rises++;
                    if (changeMid && rises == 8) begin
                        MTX_DAT = 16'($urandom);
                        STX_DAT = 16'($urandom);
                    end
                end
                prev = SCLK;
            end
        end
        st = 1'b0;
        checkOutput({tag, "_frameEnd"},  done,          1);
        checkOutput({tag, "_loadLow"},   lowCnt,        32 * TACT_DIV);
        checkOutput({tag, "_firstRise"}, firstRise - 1, TACT_DIV);
        checkOutput({tag, "_rises"},     rises,         16);
        checkOutput({tag, "_mosiSeq"},   seqM,          wireOrder(m));
        checkOutput({tag, "_misoSeq"},   seqS,          wireOrder(s));
        checkOutput({tag, "_MRX"},       MRX_DAT,       s);
        checkOutput({tag, "_SRX"},       SRX_DAT,       m);
        checkOutput({tag, "_cb"},        cb_bit,        16);
        checkOutput({tag, "_srMRX"},     sr_MRX,        s);
        checkOutput({tag, "_srSRX"},     sr_SRX,        m);
        checkOutput({tag, "_srMTX"},     sr_MTX,        0);
        checkOutput({tag, "_srSTX"},     sr_STX,        0);
        checkOutput({tag, "_SCLKidle"},  SCLK,          0);
        if (holdSt) begin
            repeat (3) @(negedge clk);
            checkOutput({tag, "_noRestart"}, LOAD, 1);
            checkOutput({tag, "_cbHold"},    cb_bit, 16);
        end
    endtask

    initial begin
        logic [15:0] rm, rs;
        logic [15:0] prevMrx;
        bit reached;

        RESET   = 1'b0;
        st      = 1'b0;
        MTX_DAT = 16'h0;
        STX_DAT = 16'h0;
        repeat (3) @(negedge clk);
        checkResetState("reset");
        RESET = 1'b1;
        @(negedge clk);

        applyStimulus(16'h1234, 16'h5678, 1'b0, 1'b0, "single");
        applyStimulus(16'hA5C3, 16'h0F0F, 1'b1, 1'b1, "busySt");
        applyStimulus(16'hABCD, 16'hFFFF, 1'b0, 1'b0, "abcdffff");

        for (int i = 0; i < 4; i++) begin
            rm = 16'($urandom);
            rs = 16'($urandom);
            applyStimulus(rm, rs, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), "random");
        end

        prevMrx = MRX_DAT;
        @(negedge clk);
        MTX_DAT = 16'hC0DE;
        STX_DAT = 16'hBEEF;
        st      = 1'b1;
        @(negedge clk);
        st = 1'b0;
        reached = 1'b0;
        for (int c = 0; c < 20 * TACT_DIV && !reached; c++) begin
            @(negedge clk);
            if (cb_bit == 8'd5) reached = 1'b1;
        end
        checkOutput("abort_reach5", reached, 1);
        checkOutput("abort_prevMRX", MRX_DAT, prevMrx);
        RESET = 1'b0;
        #1;
        checkResetState("abort");
        @(negedge clk);
        RESET = 1'b1;
        applyStimulus(16'h1234, 16'h5678, 1'b0, 1'b0, "afterAbort");

        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

endmodule
